bcd_entry: RTL and testbench
============================

# bcd_entry

Keypad digit-entry accumulator feeding the BCD-to-binary converter. Accepts one key code per handshake, builds a right-aligned, leading-zero-suppressed 6-digit packed BCD operand, and hands the finished operand downstream on a valid/ready handshake when the enter key arrives. Its `bcd_out` bus drives the converter's 24-bit BCD input directly.

## Interface
- `DIGITS`, default 6: BCD digit capacity. `bcd_out` width is 4*DIGITS. Only 6 is supported against the converter.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `key_valid`  in  1: key code present.
- `key_code`  in  5: 0x00–0x09 digit, 0x0A clear, 0x0B backspace, 0x0C enter, 0x0D–0x1F ignored.
- `key_ready`  out  1: block can accept a key.
- `bcd_out`  out  4*DIGITS: packed BCD operand; digit 0 in [3:0].
- `digit_cnt`  out  3: significant digits held, 0..DIGITS.
- `full`  out  1: `digit_cnt == DIGITS`.
- `overflow_err`  out  1: one-cycle pulse when a digit is dropped.
- `val_valid`  out  1: committed operand available on `bcd_out`.
- `val_ready`  in  1: downstream consumes the operand.

## Operation
- A key is accepted on a rising edge with `key_valid && key_ready`. `key_ready = (state != HOLD)`.
- There are three states: EMPTY, ENTRY and HOLD.
- **EMPTY** (value 0, count 0):
  - Digit 0: no change; leading zero suppressed.
  - Digit 1–9: load into digit 0, count = 1, go to ENTRY.
  - Clear, backspace or ignored code: no change.
  - Enter: go to HOLD with value 0.
- **ENTRY**:
  - Digit with count < DIGITS: shift operand left one digit, insert new digit at digit 0, count + 1.
  - Digit with count == DIGITS: digit dropped, operand unchanged, `overflow_err` pulses.
  - Backspace: shift right one digit, zero-fill the top digit, count − 1. If count was 1, go to EMPTY.
  - Clear: operand 0, count 0, go to EMPTY.
  - Enter: go to HOLD.
  - Ignored code: accepted, no effect.
- **HOLD**:
  - `val_valid = 1`. `bcd_out` and `digit_cnt` are frozen. No keys are accepted.
  - On `val_valid && val_ready`: next edge clears operand and count, goes to EMPTY.
- Every digit of `bcd_out` is always a legal BCD value (0–9).

## Timing
- Reset values: state EMPTY, `bcd_out` = 0, `digit_cnt` = 0, `full` = 0, `overflow_err` = 0, `val_valid` = 0, `key_ready` = 1.
- Outputs are registered, except `key_ready` and `full`, which decode registered state.
- Key accepted at edge N: `bcd_out`, `digit_cnt` and `overflow_err` reflect it after edge N. Back-to-back keys are supported at one per cycle.
- Enter accepted at edge N: `val_valid` = 1 and `key_ready` = 0 after edge N.
- Handshake completes at edge M: after M, `val_valid` = 0, `key_ready` = 1, `bcd_out` = 0.
- `val_ready` held high gives one HOLD cycle minimum, so commit to next key is 2 cycles.
- Asynchronous reset in any state, including HOLD with `val_ready` high, forces the reset values immediately. The pending operand is discarded, not transferred.

## Configuration
- Macro: `BCD_ENTRY_BACKSPACE_EN`.
- **Defined:** backspace (0x0B) behaves as specified above.
- **Undefined:** 0x0B is treated as an ignored code (accepted, no effect), and the backspace datapath is not built.

## Structure
- Shared package `calc_pkg` holds:
  - key-code constants `KEY_CLR`, `KEY_BS` and `KEY_ENT`;
  - `DIGITS`;
  - the state enum `entry_state_t` with values EMPTY, ENTRY and HOLD.
  - The converter and ALU reuse these.
- One sub-module, `bcd_shift_reg`, is natural: the digit register with synchronous operations load-left, shift-right and clear, plus asynchronous reset.
- The FSM, counter, and error pulse stay in `bcd_entry`.

## Test plan
- Keys 1,2,3,4,5,6, enter, `val_ready` = 1 → `bcd_out` = 0x123456, `digit_cnt` = 6, `full` = 1. `val_valid` for 1 cycle, then `bcd_out` = 0.
- Keys 0,0,7, enter → `digit_cnt` = 1, committed `bcd_out` = 0x000007.
- Six digits 9, then key 4 → `overflow_err` pulses once, `bcd_out` stays 0x999999.
- Keys 8,2, backspace, backspace, then 5 (macro defined) → 0x000082, 0x000008, 0x000000 (EMPTY), then 0x000005. With the macro undefined, the result is 0x000825.
- Enter with `val_ready` = 0 for 5 cycles → `key_ready` = 0 throughout, key presses ignored, `bcd_out` stable. `val_ready` high → transfer, then return to EMPTY.
- Assert `rst` mid-entry (0x000123) and during HOLD → all outputs take their reset values immediately; first digit after release enters into an empty operand.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: key codes, digit capacity and entry-FSM states shared by the calculator blocks
package calc_pkg;
  localparam int DIGITS = 6;
  localparam logic [4:0] KEY_CLR = 5'h0A;
  localparam logic [4:0] KEY_BS  = 5'h0B;
  localparam logic [4:0] KEY_ENT = 5'h0C;
  typedef enum logic [1:0] {EMPTY, ENTRY, HOLD} entry_state_t;
endpackage

// File: rtl/bcd_shift_reg.sv
// bcd_shift_reg: packed BCD digit register with load-left, shift-right and clear
// Shift-right exists only when BCD_ENTRY_BACKSPACE_EN is defined.
module bcd_shift_reg #(
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_load,
`ifdef BCD_ENTRY_BACKSPACE_EN
  input  logic                  i_shr,
`endif
  input  logic [3:0]            i_digit,
  output logic [4*DIGITS-1:0]   o_q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) o_q <= '0;
    else if (i_clr) o_q <= '0;
    else if (i_load) o_q <= {o_q[4*DIGITS-5:0], i_digit};
`ifdef BCD_ENTRY_BACKSPACE_EN
    else if (i_shr) o_q <= {4'd0, o_q[4*DIGITS-1:4]};
`endif
endmodule

// File: rtl/bcd_entry.sv
// bcd_entry: keypad digit-entry accumulator producing a packed BCD operand on valid/ready
// Backspace support is enabled by defining BCD_ENTRY_BACKSPACE_EN.
module bcd_entry import calc_pkg::*; #(
  parameter int DIGITS = calc_pkg::DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [4:0]          key_code,
  output logic                key_ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [2:0]          digit_cnt,
  output logic                full,
  output logic                overflow_err,
  output logic                val_valid,
  input  logic                val_ready
);
  entry_state_t r_state, w_next;
  logic [2:0] r_cnt, w_cnt;
  logic r_ovf, r_val, w_ovf, w_load, w_clr, w_shr, w_acc, w_dig;
  assign key_ready    = r_state != HOLD;
  assign full         = r_cnt == 3'(DIGITS);
  assign digit_cnt    = r_cnt;
  assign overflow_err = r_ovf;
  assign val_valid    = r_val;
  assign w_acc        = key_valid && key_ready;
  assign w_dig        = key_code <= 5'd9;
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_ovf  = 1'b0;
    w_load = 1'b0;
    w_clr  = 1'b0;
    w_shr  = 1'b0;
    case (r_state)
      EMPTY:
        if (w_acc && w_dig && key_code != 5'd0) begin
          w_load = 1'b1;
          w_cnt  = 3'd1;
          w_next = ENTRY;
        end else if (w_acc && key_code == KEY_ENT) w_next = HOLD;
      ENTRY:
        if (w_acc && w_dig) begin
          w_load = !full;
          w_ovf  = full;
          w_cnt  = full ? r_cnt : r_cnt + 3'd1;
        end else if (w_acc && key_code == KEY_CLR) begin
          w_clr  = 1'b1;
          w_cnt  = 3'd0;
          w_next = EMPTY;
        end else if (w_acc && key_code == KEY_ENT) w_next = HOLD;
`ifdef BCD_ENTRY_BACKSPACE_EN
        else if (w_acc && key_code == KEY_BS) begin
          w_shr  = 1'b1;
          w_cnt  = r_cnt - 3'd1;
          w_next = r_cnt == 3'd1 ? EMPTY : ENTRY;
        end
`endif
      HOLD:
        if (val_ready) begin
          w_clr  = 1'b1;
          w_cnt  = 3'd0;
          w_next = EMPTY;
        end
      default: w_next = EMPTY;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= EMPTY;
      r_cnt   <= 3'd0;
      r_ovf   <= 1'b0;
      r_val   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_ovf   <= w_ovf;
      r_val   <= w_next == HOLD;
    end
  bcd_shift_reg #(.DIGITS(DIGITS)) u_reg (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_load  (w_load),
`ifdef BCD_ENTRY_BACKSPACE_EN
    .i_shr   (w_shr),
`endif
    .i_digit (key_code[3:0]),
    .o_q     (bcd_out)
  );
`ifndef BCD_ENTRY_BACKSPACE_EN
  logic w_unused;
  assign w_unused = w_shr;
`endif
endmodule

// File: tb/tb_bcd_entry.sv
// tb_bcd_entry: directed plus random key sequences checked against an integer-valued entry model
module tb_bcd_entry;
  logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0, val_ready = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic key_ready, full, overflow_err, val_valid;
  logic [23:0] bcd_out;
  logic [2:0] digit_cnt;
  int n_vec = 0, n_miss = 0;
  int m_val = 0;
  bit m_hold = 0, m_ovf = 0;
`ifdef BCD_ENTRY_BACKSPACE_EN
  bit bs_en = 1;
`else
  bit bs_en = 0;
`endif
  bcd_entry dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .bcd_out(bcd_out), .digit_cnt(digit_cnt), .full(full),
    .overflow_err(overflow_err), .val_valid(val_valid), .val_ready(val_ready)
  );
  always #5 clk = ~clk;
  task automatic cmp(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(string tag);
    logic [23:0] e_bcd;
    int v, c;
    v = m_val;
    c = 0;
    for (int i = 0; i < 6; i++) begin
      e_bcd[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    for (int t = m_val; t > 0; t = t / 10) c++;
    cmp({tag, ".bcd"}, 32'(bcd_out), 32'(e_bcd));
    cmp({tag, ".cnt"}, 32'(digit_cnt), 32'(c));
    cmp({tag, ".full"}, 32'(full), 32'(c == 6));
    cmp({tag, ".ovf"}, 32'(overflow_err), 32'(m_ovf));
    cmp({tag, ".vvalid"}, 32'(val_valid), 32'(m_hold));
    cmp({tag, ".kready"}, 32'(key_ready), 32'(!m_hold));
  endtask
  task automatic step(string tag, bit kv, int code, bit vr);
    key_valid = kv;
    key_code  = 5'(code);
    val_ready = vr;
    m_ovf = 0;
    if (m_hold) begin
      if (vr) begin m_hold = 0; m_val = 0; end
    end else if (kv) begin
      if (code <= 9) begin
        if (m_val >= 100000) m_ovf = 1;
        else m_val = m_val * 10 + code;
      end else if (code == 10) m_val = 0;
      else if (code == 11 && bs_en) m_val = m_val / 10;
      else if (code == 12) m_hold = 1;
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask
  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    m_val = 0; m_hold = 0; m_ovf = 0;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    for (int d = 1; d <= 6; d++) step("seq123456", 1, d, 0);
    step("enter_hold", 1, 12, 1);
    step("xfer_done", 0, 0, 1);
    step("z0", 1, 0, 0);
    step("z1", 1, 0, 0);
    step("z7", 1, 7, 0);
    step("z_enter", 1, 12, 0);
    step("z_xfer", 0, 0, 1);
    for (int i = 0; i < 6; i++) step("nines", 1, 9, 0);
    step("ovf_pulse", 1, 4, 0);
    step("ovf_clear", 0, 0, 0);
    step("clr", 1, 10, 0);
    step("bs8", 1, 8, 0);
    step("bs2", 1, 2, 0);
    step("bs_a", 1, 11, 0);
    step("bs_b", 1, 11, 0);
    step("bs5", 1, 5, 0);
    step("bs_clr", 1, 10, 0);
    step("stall_d", 1, 3, 0);
    step("stall_ent", 1, 12, 0);
    for (int i = 0; i < 5; i++) step("stall", 1, i + 1, 0);
    step("stall_rel", 1, 6, 1);
    step("mid1", 1, 1, 0);
    step("mid2", 1, 2, 0);
    step("mid3", 1, 3, 0);
    do_reset("rst_mid");
    step("post_rst", 1, 4, 0);
    step("hold_ent", 1, 12, 0);
    val_ready = 1'b1;
    do_reset("rst_hold");
    step("post_rst2", 1, 5, 0);
    step("clr2", 1, 10, 0);
    for (int i = 0; i < 400; i++) begin
      int r, code;
      r = int'($urandom_range(0, 99));
      code = r < 70 ? int'($urandom_range(0, 9)) : r < 75 ? 10 : r < 85 ? 11 : r < 90 ? 12 : int'($urandom_range(13, 31));
      step("rand", $urandom_range(0, 3) != 0, code, $urandom_range(0, 2) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
